// File: rtl/twiddle_stream_gen.sv
// Streams radix-2 DIF twiddle factors for one FFT stage, LANES per beat, from a quarter-wave cosine ROM.
// Optional macro TWIDDLE_STREAM_INV_EN adds an `inverse` input that conjugates every coefficient.
module twiddle_stream_gen #(
  parameter int NBITS = 11,
  parameter int LOG2N = 7,
  parameter int LANES = 4,
  parameter int SW    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SW-1:0]              stage,
`ifdef TWIDDLE_STREAM_INV_EN
  input  logic                       inverse,
`endif
  output logic                       busy,
  output logic                       err,
  output logic                       coeff_valid,
  input  logic                       coeff_ready,
  output logic [NBITS*2*LANES-1:0]   coeff_data,
  output logic                       coeff_last
);

  localparam int N     = 1 << LOG2N;
  localparam int QTR   = N / 4;
  localparam int BEATS = N / (2 * LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int KW    = LOG2N - 1;
  localparam int RW    = LOG2N - 2;
  localparam int DW    = NBITS * 2 * LANES;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state, state_nx;
  logic [SW-1:0]    stage_r;
  logic [BW-1:0]    cnt;
  logic             inv_r;
  logic             legal_s, accept_s, reject_s, issue_s, last_issue_s;
  logic             out_ready_s, rom_ready_s, hs_last_s;

  logic [NBITS-1:0] rom_c [QTR+1];
  logic [KW-1:0]    k_s [LANES];
  logic [KW-1:0]    e_s [LANES];
  logic [KW-1:0]    addr_a_s [LANES];
  logic [KW-1:0]    addr_b_s [LANES];
  logic             quad_s [LANES];

  logic             rom_v, rom_last;
  logic [NBITS-1:0] ca_r [LANES];
  logic [NBITS-1:0] cb_r [LANES];
  logic             quad_r [LANES];

  logic [NBITS-1:0] re_s [LANES];
  logic [NBITS-1:0] im_s [LANES];
  logic [DW-1:0]    fold_s;

  // c[i] = round(cos(2*pi*i/N) * 2^(NBITS-2)), non-negative over the quarter wave
  for (genvar i = 0; i <= QTR; i++) begin : g_rom
    localparam real ANG = 2.0 * 3.14159265358979323846 * i / N;
    localparam int  CI  = $rtoi($cos(ANG) * (2.0 ** (NBITS - 2)) + 0.5);
    assign rom_c[i] = NBITS'(CI);
  end

  assign legal_s      = (int'(stage) < LOG2N);
  assign accept_s     = (state == IDLE) && start && legal_s;
  assign reject_s     = (state == IDLE) && start && !legal_s;
  assign out_ready_s  = !coeff_valid || coeff_ready;
  assign rom_ready_s  = !rom_v || out_ready_s;
  assign issue_s      = (state == RUN) && rom_ready_s;
  assign last_issue_s = issue_s && (cnt == BW'(BEATS - 1));
  assign hs_last_s    = coeff_valid && coeff_ready && coeff_last;

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_s) state_nx = RUN; else state_nx = IDLE;
      RUN:     if (last_issue_s) state_nx = DRAIN; else state_nx = RUN;
      DRAIN:   if (hs_last_s) state_nx = IDLE; else state_nx = DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state, stage capture, beat counter, status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      stage_r <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      err   <= reject_s;
      if (accept_s) begin
        stage_r <= stage;
        cnt     <= '0;
      end else if (issue_s) begin
        cnt <= cnt + BW'(1);
      end
    end
  end

`ifdef TWIDDLE_STREAM_INV_EN
  // conjugate selection latched with the accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_r <= 1'b0;
    end else if (accept_s) begin
      inv_r <= inverse;
    end
  end
`else
  assign inv_r = 1'b0;
`endif

  // (k mod (N >> (stage+1))) << stage equals (k << stage) truncated to log2(N/2) bits
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      k_s[l]      = KW'(int'(cnt) * LANES + l);
      e_s[l]      = k_s[l] << stage_r;
      quad_s[l]   = e_s[l][KW-1];
      addr_a_s[l] = {1'b0, e_s[l][RW-1:0]};
      addr_b_s[l] = KW'(QTR) - addr_a_s[l];
    end
  end

  // registered ROM read: cosine of r and of N/4-r per lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_v    <= 1'b0;
      rom_last <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        ca_r[l]   <= '0;
        cb_r[l]   <= '0;
        quad_r[l] <= 1'b0;
      end
    end else if (rom_ready_s) begin
      rom_v    <= issue_s;
      rom_last <= last_issue_s;
      if (issue_s) begin
        for (int l = 0; l < LANES; l++) begin
          ca_r[l]   <= rom_c[addr_a_s[l]];
          cb_r[l]   <= rom_c[addr_b_s[l]];
          quad_r[l] <= quad_s[l];
        end
      end
    end
  end

  // quadrant fold and optional conjugation
  always_comb begin
    fold_s = '0;
    for (int l = 0; l < LANES; l++) begin
      if (quad_r[l]) begin
        re_s[l] = -cb_r[l];
        im_s[l] = -ca_r[l];
      end else begin
        re_s[l] = ca_r[l];
        im_s[l] = -cb_r[l];
      end
      if (inv_r) begin
        im_s[l] = -im_s[l];
      end else begin
        im_s[l] = im_s[l];
      end
      fold_s[(LANES-1-l)*2*NBITS +: 2*NBITS] = {re_s[l], im_s[l]};
    end
  end

  // output register; holds while the downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coeff_valid <= 1'b0;
      coeff_data  <= '0;
      coeff_last  <= 1'b0;
    end else if (out_ready_s) begin
      coeff_valid <= rom_v;
      coeff_data  <= rom_v ? fold_s : '0;
      coeff_last  <= rom_v && rom_last;
    end
  end

endmodule
